// File: rtl/pfcop_pkg.sv
// Shared constants and types for the PFCOP command sequencer.
// Opcodes, PFCOP load/read addresses and the sequencer state encoding.
package pfcop_pkg;

  localparam int WORDS  = 16;
  localparam int WORD_W = 16;

  localparam logic [1:0] OP_MADD = 2'd0;
  localparam logic [1:0] OP_MSUB = 2'd1;
  localparam logic [1:0] OP_MMUL = 2'd2;
  localparam logic [1:0] OP_MINV = 2'd3;

  localparam logic [3:0] LA_A = 4'd6;
  localparam logic [3:0] LA_B = 4'd7;
  localparam logic [3:0] LA_P = 4'd8;

  localparam logic [1:0] OA_ADD = 2'd0;
  localparam logic [1:0] OA_MUL = 2'd1;
  localparam logic [1:0] OA_INV = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_P,
    S_START,
    S_WAIT,
    S_READ,
    S_DONE
  } state_t;

  typedef logic [WORDS-1:0][WORD_W-1:0] opnd_t;

  function automatic logic [1:0] out_code(
    input logic [1:0] op
  );
    logic [1:0] r;
    r = OA_ADD;
    if (op == OP_MMUL) r = OA_MUL;
    if (op == OP_MINV) r = OA_INV;
    return r;
  endfunction

endpackage

// File: rtl/pfcop_rd_deser.sv
// Result capture: one 16-bit word per enabled cycle into a 16x16 register.
// Synchronous clear zeroes the whole result (watchdog abort path).
module pfcop_rd_deser
  import pfcop_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic [3:0]              i_idx,
  input  logic [WORD_W-1:0]       i_word,
  output logic [WORDS*WORD_W-1:0] o_data
);

  opnd_t r_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
    end else if (i_clr) begin
      r_mem <= '0;
    end else if (i_en) begin
      r_mem[i_idx] <= i_word;
    end
  end

  assign o_data = r_mem;

endmodule

// File: rtl/pfcop_cmd_seq.sv
// Host command sequencer for PFCOP: load operands, start, wait, read result.
// Optional watchdog on the WAIT state enabled by PFCOP_SEQ_TIMEOUT_EN.
module pfcop_cmd_seq
  import pfcop_pkg::*;
#(
  parameter int OUT_LAT = 1,
  parameter int TMO_CYC = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic         cmd_inv,
  input  logic [255:0] op_a,
  input  logic [255:0] op_b,
  input  logic [255:0] op_p,
  output logic         load_en,
  output logic [3:0]   load_addr,
  output logic [15:0]  datain,
  output logic         madd_en,
  output logic         msub_en,
  output logic         mmul_en,
  output logic         minv_mdiv_en,
  output logic         minv_mdiv,
  output logic         out_en,
  output logic [1:0]   out_addr,
  input  logic [15:0]  dataout,
  input  logic         madd_msub_rdy,
  input  logic         mmul_rdy,
  input  logic         minv_mdiv_rdy,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [255:0] res_data,
  output logic         res_err
);

  localparam logic [15:0] LAT_M1 =
    (OUT_LAT > 0) ? 16'(OUT_LAT - 1) : 16'd0;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_lat;
  logic        r_cap;
  logic [1:0]  r_op;
  logic        r_inv;
  opnd_t       r_a;
  opnd_t       r_b;
  opnd_t       r_p;

  logic [3:0]  w_cnt_nx;
  logic        w_rdy;
  logic        w_tmo_hit;
  logic        w_cap_en;

  assign w_cnt_nx = r_cnt + 4'd1;
  assign w_cap_en = (r_state == S_READ) && r_cap;

  always_comb begin
    w_rdy = madd_msub_rdy;
    unique case (r_op)
      OP_MMUL: w_rdy = mmul_rdy;
      OP_MINV: w_rdy = minv_mdiv_rdy;
      default: w_rdy = madd_msub_rdy;
    endcase
  end

`ifdef PFCOP_SEQ_TIMEOUT_EN
  logic [15:0] r_tmo;
  logic        r_err;

  assign w_tmo_hit = (r_state == S_WAIT) && !w_rdy &&
                     (r_tmo == 16'(TMO_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_START) r_tmo <= '0;
      else if (r_state == S_WAIT) r_tmo <= r_tmo + 16'd1;
      if (w_tmo_hit) r_err <= 1'b1;
      else if (r_state == S_DONE && res_ready) r_err <= 1'b0;
    end
  end

  assign res_err = r_err;
`else
  assign w_tmo_hit = 1'b0;
  assign res_err   = 1'b0;
`endif

  pfcop_rd_deser u_deser (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tmo_hit),
    .i_en   (w_cap_en),
    .i_idx  (r_cnt),
    .i_word (dataout),
    .o_data (res_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_lat        <= '0;
      r_cap        <= 1'b0;
      r_op         <= '0;
      r_inv        <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_p          <= '0;
      cmd_ready    <= 1'b1;
      load_en      <= 1'b0;
      load_addr    <= '0;
      datain       <= '0;
      madd_en      <= 1'b0;
      msub_en      <= 1'b0;
      mmul_en      <= 1'b0;
      minv_mdiv_en <= 1'b0;
      minv_mdiv    <= 1'b0;
      out_en       <= 1'b0;
      out_addr     <= '0;
      res_valid    <= 1'b0;
    end else begin
      madd_en      <= 1'b0;
      msub_en      <= 1'b0;
      mmul_en      <= 1'b0;
      minv_mdiv_en <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op      <= cmd_op;
            r_inv     <= cmd_inv;
            r_a       <= op_a;
            r_b       <= op_b;
            r_p       <= op_p;
            minv_mdiv <= cmd_inv;
            out_addr  <= out_code(cmd_op);
            cmd_ready <= 1'b0;
            load_en   <= 1'b1;
            load_addr <= LA_A;
            datain    <= op_a[15:0];
            r_cnt     <= '0;
            r_state   <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          if (r_cnt == 4'd15) begin
            r_cnt <= '0;
            // minv needs no b operand
            if (r_op == OP_MINV && r_inv) begin
              load_addr <= LA_P;
              datain    <= r_p[0];
              r_state   <= S_LOAD_P;
            end else begin
              load_addr <= LA_B;
              datain    <= r_b[0];
              r_state   <= S_LOAD_B;
            end
          end else begin
            r_cnt  <= w_cnt_nx;
            datain <= r_a[w_cnt_nx];
          end
        end
        S_LOAD_B: begin
          if (r_cnt == 4'd15) begin
            r_cnt     <= '0;
            load_addr <= LA_P;
            datain    <= r_p[0];
            r_state   <= S_LOAD_P;
          end else begin
            r_cnt  <= w_cnt_nx;
            datain <= r_b[w_cnt_nx];
          end
        end
        S_LOAD_P: begin
          if (r_cnt == 4'd15) begin
            r_cnt        <= '0;
            load_en      <= 1'b0;
            load_addr    <= '0;
            datain       <= '0;
            madd_en      <= (r_op == OP_MADD);
            msub_en      <= (r_op == OP_MSUB);
            mmul_en      <= (r_op == OP_MMUL);
            minv_mdiv_en <= (r_op == OP_MINV);
            r_state      <= S_START;
          end else begin
            r_cnt  <= w_cnt_nx;
            datain <= r_p[w_cnt_nx];
          end
        end
        S_START: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_rdy) begin
            out_en  <= 1'b1;
            r_cnt   <= '0;
            r_lat   <= '0;
            r_cap   <= (OUT_LAT == 0);
            r_state <= S_READ;
          end else if (w_tmo_hit) begin
            res_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_READ: begin
          // first OUT_LAT cycles of the window carry no data
          if (!r_cap) begin
            r_lat <= r_lat + 16'd1;
            if (r_lat == LAT_M1) r_cap <= 1'b1;
          end else if (r_cnt == 4'd15) begin
            r_cnt     <= '0;
            r_cap     <= 1'b0;
            out_en    <= 1'b0;
            res_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= w_cnt_nx;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
